// File: rtl/serial_sub32_pkg.sv
// rtl/serial_sub32_pkg.sv - shared types and sizing for the serial subtractor
package serial_sub32_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
  localparam int CNT_W     = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub32_sub_slice.sv
// rtl/serial_sub32_sub_slice.sv - combinational SLICE-bit full subtractor
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             b_in,
  output logic [SLICE-1:0] d,
  output logic             b_out
);
  // One extra bit catches the borrow as the wrapped MSB.
  assign {b_out, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, b_in};
endmodule

// File: rtl/serial_sub32.sv
// rtl/serial_sub32.sv - multi-cycle A - B - Bin, one slice per clock
module serial_sub32
  import serial_sub32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);
  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             brw_q, brw_d, bout_q, bout_d, v_q, v_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_d;
  logic             sl_bout;

  assign sl_a = a_q[cnt_q*SLICE +: SLICE];
  assign sl_b = b_q[cnt_q*SLICE +: SLICE];

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .b_in  (brw_q),
    .d     (sl_d),
    .b_out (sl_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        d_d[cnt_q*SLICE +: SLICE] = sl_d;
        brw_d = sl_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NS - 1)) begin
          // Flags settle with the last slice so they are valid alongside done.
          bout_d  = sl_bout;
          v_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sl_d[SLICE-1] ^ a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;
endmodule
